io_controller: RTL and testbench

- Memory-side I/O block between the riscv_pipeline I/O ports and the byte-level UART rx/tx units.
- Buffers received UART bytes, packs them into 32-bit words, and serves them to the core's in requests.
- Buffers the core's out bytes and drains them to the UART transmitter under a valid/ready handshake.
- Drives io_stall whenever a core request cannot complete in the current cycle.

---
 rtl/io_controller_if.sv | 29 ++
 rtl/io_controller.sv | 153 +++++++++++++++
 tb/tb_io_controller.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_controller_if.sv
// Bus interface for io_controller: core in/out request port plus UART byte port.
// The controller takes the slave side; the core/UART side (or a bench) takes master.
interface io_controller_if #(
    parameter int RX_DEPTH_LOG2 = 4
);
    logic                     in_issued;
    logic                     out_issued;
    logic [31:0]              out_data;
    logic [31:0]              in_data;
    logic                     in_data_valid;
    logic                     io_stall;
    logic [7:0]               rx_byte;
    logic                     rx_valid;
    logic [7:0]               tx_byte;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     rx_overflow;
    logic [RX_DEPTH_LOG2:0]   rx_count;

    modport master (
        output in_issued, out_issued, out_data, rx_byte, rx_valid, tx_ready,
        input  in_data, in_data_valid, io_stall, tx_byte, tx_valid, rx_overflow, rx_count
    );

    modport slave (
        input  in_issued, out_issued, out_data, rx_byte, rx_valid, tx_ready,
        output in_data, in_data_valid, io_stall, tx_byte, tx_valid, rx_overflow, rx_count
    );
endinterface

// File: rtl/io_controller.sv
// io_controller: RX byte -> word FIFO feeding core in requests, TX byte FIFO
// fed by core out requests and drained to the UART under valid/ready.
// Optional macro IO_RX_WORD_EN: when defined, RX bytes are packed four to a
// little-endian word; when undefined, each byte is pushed as {24'b0, byte}.
module io_controller #(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 6
) (
    input logic            clk,
    input logic            rst,
    io_controller_if.slave bus
);
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE = RX_DEPTH_LOG2'(1);
    localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE = TX_DEPTH_LOG2'(1);
    localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE = (RX_DEPTH_LOG2+1)'(1);
    localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE = (TX_DEPTH_LOG2+1)'(1);
    localparam logic [RX_DEPTH_LOG2:0]   RX_FULL    = (RX_DEPTH_LOG2+1)'(RX_DEPTH);
    localparam logic [TX_DEPTH_LOG2:0]   TX_FULL    = (TX_DEPTH_LOG2+1)'(TX_DEPTH);

    logic [31:0]              rx_mem_q [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_DEPTH_LOG2:0]   rx_count_q, rx_count_d;
    logic                     rx_overflow_q, rx_overflow_d;
    logic [31:0]              in_data_q, in_data_d;

    logic [7:0]               tx_mem_q [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_DEPTH_LOG2:0]   tx_count_q, tx_count_d;

    logic        rx_push_req, rx_push, rx_pop, rx_empty, rx_full;
    logic [31:0] rx_push_word, rx_head;
    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic        in_fire;
    logic        unused_out_hi;

    // only the low byte of an out payload is ever transmitted
    assign unused_out_hi = ^bus.out_data[31:8];

`ifdef IO_RX_WORD_EN
    logic [23:0] pack_q, pack_d;
    logic [1:0]  idx_q, idx_d;

    // collect three bytes in the pack register; the fourth completes the word
    always_comb begin
        pack_d       = pack_q;
        idx_d        = idx_q;
        rx_push_req  = 1'b0;
        rx_push_word = {bus.rx_byte, pack_q};
        if (bus.rx_valid) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    pack_d[7:0]   = bus.rx_byte;
                2'd1:    pack_d[15:8]  = bus.rx_byte;
                2'd2:    pack_d[23:16] = bus.rx_byte;
                default: rx_push_req   = 1'b1;
            endcase
        end
    end

    // pack register and lane index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack_q <= '0;
            idx_q  <= '0;
        end else begin
            pack_q <= pack_d;
            idx_q  <= idx_d;
        end
    end
`else
    // byte mode: every received byte is a word of its own
    always_comb begin
        rx_push_req  = bus.rx_valid;
        rx_push_word = {24'h0, bus.rx_byte};
    end
`endif

    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == RX_FULL);
    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == TX_FULL);
    assign rx_head  = rx_mem_q[rx_rd_ptr_q];

    // out wins if the core ever raises both requests; the in side then waits
    assign in_fire = bus.in_issued && !bus.out_issued && !rx_empty;
    assign rx_pop  = in_fire;
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign rx_push = rx_push_req && (!rx_full || rx_pop);
    assign tx_push = bus.out_issued && !tx_full;
    assign tx_pop  = !tx_empty && bus.tx_ready;

    assign bus.io_stall      = bus.out_issued ? tx_full : (bus.in_issued && rx_empty);
    assign bus.in_data_valid = in_fire;
    assign bus.in_data       = in_fire ? rx_head : in_data_q;
    assign bus.tx_valid      = !tx_empty;
    assign bus.tx_byte       = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
    assign bus.rx_overflow   = rx_overflow_q;
    assign bus.rx_count      = rx_count_q;

    // next-state for both FIFOs, the sticky overflow flag and the in_data hold
    always_comb begin
        rx_wr_ptr_d   = rx_push ? rx_wr_ptr_q + RX_PTR_ONE : rx_wr_ptr_q;
        rx_rd_ptr_d   = rx_pop  ? rx_rd_ptr_q + RX_PTR_ONE : rx_rd_ptr_q;
        rx_count_d    = rx_count_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - RX_CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
        rx_overflow_d = rx_overflow_q || (rx_push_req && !rx_push);
        in_data_d     = in_fire ? rx_head : in_data_q;

        tx_wr_ptr_d   = tx_push ? tx_wr_ptr_q + TX_PTR_ONE : tx_wr_ptr_q;
        tx_rd_ptr_d   = tx_pop  ? tx_rd_ptr_q + TX_PTR_ONE : tx_rd_ptr_q;
        tx_count_d    = tx_count_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + TX_CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - TX_CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase
    end

    // control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            rx_overflow_q <= 1'b0;
            in_data_q     <= '0;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
        end else begin
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            rx_overflow_q <= rx_overflow_d;
            in_data_q     <= in_data_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
        end
    end

    // FIFO storage needs no reset; occupancy counters gate every read
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_push_word;
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.out_data[7:0];
    end
endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller (works with or without IO_RX_WORD_EN).
module tb_io_controller;
`ifdef IO_RX_WORD_EN
    localparam int BPW = 4;
`else
    localparam int BPW = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    io_controller_if #(.RX_DEPTH_LOG2(4)) bus ();
    io_controller #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [31:0] rx_q [$];
    logic [7:0]  tx_q [$];
    logic        ovf_m = 1'b0;
    logic [23:0] pack_m = '0;
    int          idx_m = 0;
    logic [31:0] last_in = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        ovf_m   = 1'b0;
        pack_m  = '0;
        idx_m   = 0;
        last_in = 32'h0;
    endtask

    task automatic model_byte(input logic [7:0] b);
`ifdef IO_RX_WORD_EN
        case (idx_m)
            0: pack_m[7:0]   = b;
            1: pack_m[15:8]  = b;
            2: pack_m[23:16] = b;
            default: begin
                if (rx_q.size() < 16) rx_q.push_back({b, pack_m});
                else ovf_m = 1'b1;
            end
        endcase
        idx_m = (idx_m + 1) % 4;
`else
        if (rx_q.size() < 16) rx_q.push_back({24'h0, b});
        else ovf_m = 1'b1;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        model_byte(b);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < BPW; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic read_one(input string name);
        int n = 0;
        logic [31:0] exp;
        bus.in_issued = 1'b1;
        #1;
        while (bus.io_stall && n < 50) begin
            tick();
            #1;
            n++;
        end
        total++;
        if (bus.io_stall) begin
            bad++;
            $display("FAIL %s_timeout: io_stall=%b want 0", name, bus.io_stall);
        end else if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL %s_unexpected: got in_data=%h want no word available", name, bus.in_data);
        end else begin
            exp = rx_q.pop_front();
            last_in = exp;
            if (bus.in_data_valid !== 1'b1 || bus.in_data !== exp) begin
                bad++;
                $display("FAIL %s: got valid=%b data=%h want valid=1 data=%h",
                         name, bus.in_data_valid, bus.in_data, exp);
            end
        end
        tick();
        bus.in_issued = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if (bus.in_data !== 32'h0 || bus.in_data_valid !== 1'b0 || bus.io_stall !== 1'b0 ||
            bus.tx_valid !== 1'b0 || bus.tx_byte !== 8'h0 || bus.rx_overflow !== 1'b0 ||
            bus.rx_count !== 5'd0) begin
            bad++;
            $display("FAIL %s: got in_data=%h vld=%b stall=%b txv=%b txb=%h ovf=%b cnt=%0d want all 0",
                     name, bus.in_data, bus.in_data_valid, bus.io_stall, bus.tx_valid,
                     bus.tx_byte, bus.rx_overflow, bus.rx_count);
        end
    endtask

    task automatic drain_tx(input string name);
        int n = 0;
        bus.tx_ready = 1'b1;
        while (tx_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (tx_q.size() != 0 || bus.tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: got left=%0d tx_valid=%b want 0 0", name, tx_q.size(), bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
    endtask

    // TX scoreboard: every accepted byte must match the next queued one
    always @(negedge clk) begin
        if (rst && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got tx_byte=%h want nothing pending", bus.tx_byte);
            end else begin
                logic [7:0] e;
                e = tx_q.pop_front();
                if (bus.tx_byte !== e) begin
                    bad++;
                    $display("FAIL tx_order: got %h want %h", bus.tx_byte, e);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) tick();
        check_outputs_zero("reset_initial");
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) send_word(32'h5500_0000 + i);
        if (BPW == 4) begin
            send_byte(8'h11);
            send_byte(8'h22);
        end
        rst = 1'b0;
        #1;
        check_outputs_zero("reset_midstream");
        tick();
        rst = 1'b1;
        model_reset();
        tick();
        send_word(32'hCAFE_F00D);
        read_one("reset_fresh_word");
    endtask

    task automatic test_rx_pack();
        send_word(32'h1234_5678);
        total++;
        if (bus.rx_count !== 5'd1) begin
            bad++;
            $display("FAIL pack_count: got %0d want 1", bus.rx_count);
        end
        read_one("pack_word");
        #1;
        total++;
        if (bus.in_data_valid !== 1'b0 || bus.in_data !== last_in || bus.rx_count !== 5'd0) begin
            bad++;
            $display("FAIL pack_after: got vld=%b data=%h cnt=%0d want 0 %h 0",
                     bus.in_data_valid, bus.in_data, bus.rx_count, last_in);
        end
    endtask

    task automatic test_in_empty();
        logic [7:0] b [4];
        logic [31:0] exp;
        b[0] = 8'hEF; b[1] = 8'hBE; b[2] = 8'hAD; b[3] = 8'hDE;
        bus.in_issued = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (bus.io_stall !== 1'b1 || bus.in_data_valid !== 1'b0) begin
                bad++;
                $display("FAIL empty_stall_%0d: got stall=%b vld=%b want 1 0", i, bus.io_stall, bus.in_data_valid);
            end
            tick();
        end
        for (int i = 0; i < BPW; i++) begin
            bus.rx_byte  = b[i];
            bus.rx_valid = 1'b1;
            model_byte(b[i]);
            #1;
            total++;
            if (bus.io_stall !== 1'b1) begin
                bad++;
                $display("FAIL empty_byte_stall_%0d: got %b want 1", i, bus.io_stall);
            end
            tick();
            bus.rx_valid = 1'b0;
        end
        #1;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hXXXX_XXXX;
        last_in = exp;
        total++;
        if (bus.io_stall !== 1'b0 || bus.in_data_valid !== 1'b1 || bus.in_data !== exp) begin
            bad++;
            $display("FAIL empty_complete: got stall=%b vld=%b data=%h want 0 1 %h",
                     bus.io_stall, bus.in_data_valid, bus.in_data, exp);
        end
        tick();
        bus.in_issued = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) send_word(32'hA0B0_C000 + 32'(i + 1));
        total++;
        if (bus.rx_count !== 5'd16 || bus.rx_overflow !== ovf_m || ovf_m !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b want 16 1", bus.rx_count, bus.rx_overflow);
        end
        for (int i = 0; i < 16; i++) read_one($sformatf("ovf_read_%0d", i));
        total++;
        if (bus.rx_count !== 5'd0 || bus.rx_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got cnt=%0d ovf=%b want 0 1", bus.rx_count, bus.rx_overflow);
        end
    endtask

    task automatic test_tx_backpressure();
        int n = 0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus.out_issued = 1'b1;
            bus.out_data   = {24'($urandom), 8'(i)};
            #1;
            total++;
            if (bus.io_stall !== 1'b0) begin
                bad++;
                $display("FAIL tx_fill_%0d: got stall=%b want 0", i, bus.io_stall);
            end
            tx_q.push_back(8'(i));
            tick();
        end
        bus.out_data = {24'($urandom), 8'd64};
        #1;
        total++;
        if (bus.io_stall !== 1'b1 || bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h00) begin
            bad++;
            $display("FAIL tx_full_stall: got stall=%b txv=%b txb=%h want 1 1 00",
                     bus.io_stall, bus.tx_valid, bus.tx_byte);
        end
        repeat (3) tick();
        total++;
        if (bus.io_stall !== 1'b1) begin
            bad++;
            $display("FAIL tx_full_hold: got stall=%b want 1", bus.io_stall);
        end
        bus.tx_ready = 1'b1;
        #1;
        while (bus.io_stall && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (bus.io_stall !== 1'b0) begin
            bad++;
            $display("FAIL tx_release: got stall=%b want 0", bus.io_stall);
        end
        tx_q.push_back(8'd64);
        tick();
        bus.out_issued = 1'b0;
        drain_tx("tx_bp");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 20; i++) begin
            int n = 0;
            bus.out_issued = 1'b1;
            bus.out_data   = $urandom;
            bus.tx_ready   = 1'($urandom_range(0, 1));
            #1;
            while (bus.io_stall && n < 10) begin
                tick();
                bus.tx_ready = 1'($urandom_range(0, 1));
                #1;
                n++;
            end
            tx_q.push_back(bus.out_data[7:0]);
            tick();
        end
        bus.out_issued = 1'b0;
        drain_tx("b2b_tx");
        for (int i = 0; i < 3; i++) send_word($urandom);
        bus.in_issued = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            w = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hXXXX_XXXX;
            total++;
            if (bus.io_stall !== 1'b0 || bus.in_data_valid !== 1'b1 || bus.in_data !== w) begin
                bad++;
                $display("FAIL b2b_rx_%0d: got stall=%b vld=%b data=%h want 0 1 %h",
                         i, bus.io_stall, bus.in_data_valid, bus.in_data, w);
            end
            tick();
        end
        #1;
        total++;
        if (bus.io_stall !== 1'b1 || bus.rx_count !== 5'd0) begin
            bad++;
            $display("FAIL b2b_rx_empty: got stall=%b cnt=%0d want 1 0", bus.io_stall, bus.rx_count);
        end
        tick();
        bus.in_issued = 1'b0;
    endtask

`ifndef IO_RX_WORD_EN
    task automatic test_byte_mode();
        send_byte(8'hA5);
        bus.in_issued = 1'b1;
        #1;
        total++;
        if (bus.in_data !== 32'h0000_00A5 || bus.in_data_valid !== 1'b1) begin
            bad++;
            $display("FAIL byte_mode: got vld=%b data=%h want 1 000000a5", bus.in_data_valid, bus.in_data);
        end
        void'(rx_q.pop_front());
        tick();
        bus.in_issued = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_issued  = 1'b0;
        bus.out_issued = 1'b0;
        bus.out_data   = 32'h0;
        bus.rx_byte    = 8'h0;
        bus.rx_valid   = 1'b0;
        bus.tx_ready   = 1'b0;
        test_reset();
        test_rx_pack();
        test_in_empty();
        test_tx_backpressure();
        test_back_to_back();
`ifndef IO_RX_WORD_EN
        test_byte_mode();
`endif
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
